// File: rtl/mini_cpu_if.sv
// rtl/mini_cpu_if.sv - memory bus between mini_cpu and a combinational-read memory
interface mini_cpu_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          we;
  logic [DW-1:0] data_in;

  modport master (output addr, output data_out, output we, input data_in);
  modport slave  (input addr, input data_out, input we, output data_in);
endinterface

// File: rtl/mini_cpu.sv
// rtl/mini_cpu.sv - accumulator CPU: FETCH/DECODE/OPER/MEM/HALT over a single memory bus
module mini_cpu #(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      rst,
  mini_cpu_if.master bus,
  output logic      halted,
  output logic      zero,
  output logic      carry
);

  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JZ   = 4'd2;
  localparam logic [3:0] OP_LDA  = 4'd3;
  localparam logic [3:0] OP_STA  = 4'd4;
  localparam logic [3:0] OP_LDI  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_MOVB = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd9;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPER, S_MEM, S_HALT} state_t;

  state_t        r_state, w_state;
  logic [DW-1:0] r_a, w_a, r_b, w_b, r_inst, w_inst, r_opnd, w_opnd;
  logic [AW-1:0] r_pc, w_pc, r_addr, w_addr;
  logic [DW-1:0] r_data_out, w_data_out;
  logic          r_we, w_we, r_carry, w_carry;

  logic [3:0]    w_dec_op, w_cur_op;
  logic [DW:0]   w_sum, w_diff;
  logic [AW-1:0] w_pc_inc, w_target;
  logic          w_unused_bits;

  assign w_dec_op = bus.data_in[DW-1:DW-4];
  assign w_cur_op = r_inst[DW-1:DW-4];
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff   = {1'b0, r_a} - {1'b0, r_b};
  assign w_pc_inc = r_pc + AW'(1);
  assign w_target = AW'(bus.data_in);
  // opnd is kept as architectural state; the operand itself is consumed straight off the bus
  assign w_unused_bits = ^{r_opnd, r_inst[DW-5:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_a        <= '0;
      r_b        <= '0;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_opnd     <= '0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_we       <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_a        <= w_a;
      r_b        <= w_b;
      r_pc       <= w_pc;
      r_inst     <= w_inst;
      r_opnd     <= w_opnd;
      r_addr     <= w_addr;
      r_data_out <= w_data_out;
      r_we       <= w_we;
      r_carry    <= w_carry;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_a        = r_a;
    w_b        = r_b;
    w_pc       = r_pc;
    w_inst     = r_inst;
    w_opnd     = r_opnd;
    w_addr     = r_addr;
    w_data_out = r_data_out;
    w_we       = r_we;
    w_carry    = r_carry;
    case (r_state)
      S_FETCH: begin
        w_addr  = r_pc;
        w_we    = 1'b0;
        w_state = S_DECODE;
      end
      S_DECODE: begin
        w_inst  = bus.data_in;
        w_pc    = w_pc_inc;
        w_state = S_FETCH;
        case (w_dec_op)
          OP_ADD:  {w_carry, w_a} = w_sum;
          OP_SUB:  {w_carry, w_a} = w_diff;
          OP_MOVB: w_b = r_a;
          OP_HLT:  w_state = S_HALT;
          OP_JMP, OP_JZ, OP_LDI, OP_LDA, OP_STA: begin
            w_addr  = w_pc_inc;
            w_state = S_OPER;
          end
          default: ;
        endcase
      end
      S_OPER: begin
        w_opnd  = bus.data_in;
        w_pc    = w_pc_inc;
        w_state = S_FETCH;
        case (w_cur_op)
          OP_JMP: w_pc = w_target;
          OP_JZ:  if (r_a == '0) w_pc = w_target;
          OP_LDI: w_a = bus.data_in;
          OP_LDA: begin
            w_addr  = w_target;
            w_state = S_MEM;
          end
          OP_STA: begin
            w_addr     = w_target;
            w_data_out = r_a;
            w_we       = 1'b1;
            w_state    = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (w_cur_op == OP_LDA) w_a = bus.data_in;
        w_we    = 1'b0;
        w_state = S_FETCH;
      end
      S_HALT: w_we = 1'b0;
      default: w_state = S_FETCH;
    endcase
  end

  assign bus.addr     = r_addr;
  assign bus.data_out = r_data_out;
  assign bus.we       = r_we;
  assign halted       = (r_state == S_HALT);
  assign zero         = (r_a == '0);
  assign carry        = r_carry;

endmodule

// File: tb/tb_mini_cpu.sv
// tb/tb_mini_cpu.sv - program table plus timing sequences for mini_cpu, store scoreboard on the bus
module tb_mini_cpu;

  logic clk, rst;
  logic halted, zero, carry;
  logic [7:0] mem [256];
  int n_run, n_fail;

  mini_cpu_if #(.DW(8), .AW(8)) bus ();

  mini_cpu #(.DW(8), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .zero(zero), .carry(carry)
  );

  assign bus.data_in = mem[bus.addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.we) mem[bus.addr] = bus.data_out;

  typedef struct packed {
    logic [0:11][7:0] prog;
    logic        far_en;
    logic [7:0]  far_a, far_d;
    logic        st_en;
    logic [7:0]  st_a, st_d;
    logic [7:0]  ea;
    logic        ec;
    logic [7:0]  epc;
  } vec_t;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} st_t;
  st_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle with we high must match the next queued store
  always @(posedge clk) begin
    #1;
    if (!rst && bus.we) begin
      if (sb.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        st_t e;
        e = sb.pop_front();
        chk("st_addr", bus.addr, e.a);
        chk("st_data", bus.data_out, e.d);
      end
    end
  end

  function automatic vec_t mk(input logic [95:0] p, input logic fe, input logic [7:0] fa, fd,
                              input logic se, input logic [7:0] sa, sd, ea, input logic ec,
                              input logic [7:0] epc);
    vec_t v;
    v.prog = p; v.far_en = fe; v.far_a = fa; v.far_d = fd;
    v.st_en = se; v.st_a = sa; v.st_d = sd; v.ea = ea; v.ec = ec; v.epc = epc;
    return v;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit done;
    logic [7:0] pc_hold;
    clear_mem();
    for (int i = 0; i < 12; i++) mem[i] = v.prog[i];
    if (v.far_en) mem[v.far_a] = v.far_d;
    if (v.st_en) sb.push_back('{a: v.st_a, d: v.st_d});
    do_reset();
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (halted) done = 1;
    end
    chk($sformatf("v%0d_halted", idx), halted, 1);
    chk($sformatf("v%0d_a", idx), dut.r_a, v.ea);
    chk($sformatf("v%0d_carry", idx), carry, v.ec);
    chk($sformatf("v%0d_zero", idx), zero, (v.ea == 8'h00));
    chk($sformatf("v%0d_pc", idx), dut.r_pc, v.epc);
    if (v.st_en) chk($sformatf("v%0d_mem", idx), mem[v.st_a], v.st_d);
    pc_hold = dut.r_pc;
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_hold_pc", idx), dut.r_pc, pc_hold);
    chk($sformatf("v%0d_hold_we", idx), bus.we, 0);
    chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
  endtask

  vec_t tbl [11];

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1;
    clear_mem();
    tbl[0]  = mk(96'h50_05_80_50_03_60_40_40_90_00_00_00, 0, 8'h00, 8'h00, 1, 8'h40, 8'h08, 8'h08, 0, 8'h09);
    tbl[1]  = mk(96'h50_FF_80_50_01_60_90_00_00_00_00_00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 8'h07);
    tbl[2]  = mk(96'h50_FF_80_50_01_60_70_90_00_00_00_00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 8'h08);
    tbl[3]  = mk(96'h20_20_50_77_90_00_00_00_00_00_00_00, 1, 8'h20, 8'h90, 0, 8'h00, 8'h00, 8'h00, 0, 8'h21);
    tbl[4]  = mk(96'h50_01_20_20_90_00_00_00_00_00_00_00, 1, 8'h20, 8'h90, 0, 8'h00, 8'h00, 8'h01, 0, 8'h05);
    tbl[5]  = mk(96'h30_10_90_00_00_00_00_00_00_00_00_00, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 8'hA5, 0, 8'h03);
    tbl[6]  = mk(96'h50_03_8F_A5_50_04_6F_FF_90_00_00_00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h07, 0, 8'h09);
    tbl[7]  = mk(96'h10_08_50_11_90_00_00_00_50_22_90_00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h22, 0, 8'h0B);
    tbl[8]  = mk(96'h50_05_80_50_09_70_90_00_00_00_00_00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h04, 0, 8'h07);
    tbl[9]  = mk(96'h30_10_40_11_90_00_00_00_00_00_00_00, 1, 8'h10, 8'hA5, 1, 8'h11, 8'hA5, 8'hA5, 0, 8'h05);
    tbl[10] = mk(96'h50_FF_80_60_40_30_50_00_90_00_00_00, 0, 8'h00, 8'h00, 1, 8'h30, 8'hFE, 8'h00, 1, 8'h09);
    for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

    // asynchronous reset from a halted core with carry and data_out set
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 8'h00);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_pc", dut.r_pc, 8'h00);

    // LDA latency and we quiet throughout
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h10; mem[8'h10] = 8'hA5;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("lda_we_c%0d", c), bus.we, 0);
      if (c == 3) chk("lda_a_c3", dut.r_a, 8'h00);
      if (c == 4) chk("lda_a_c4", dut.r_a, 8'hA5);
    end

    // JZ taken lands after 3 cycles
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h20;
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("jz_pc_c3", dut.r_pc, 8'h20);

    // JMP 0xFF then NOP at 0xFF wraps pc to 0
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("jmp_pc_ff", dut.r_pc, 8'hFF);
    repeat (2) @(posedge clk);
    #1 chk("wrap_pc_00", dut.r_pc, 8'h00);

    // reset during STA MEM cycle suppresses the write
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h3C; mem[2] = 8'h40; mem[3] = 8'h40; mem[4] = 8'h90;
    mem[8'h40] = 8'h11;
    sb.push_back('{a: 8'h40, d: 8'h3C});
    do_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sta_we_mem", bus.we, 1);
    rst = 1'b1;
    #1 chk("sta_we_async_drop", bus.we, 0);
    @(posedge clk); #1;
    chk("sta_mem_unchanged", mem[8'h40], 8'h11);
    chk("sta_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_addr", bus.addr, 8'h00);
    @(posedge clk); #1;
    chk("restart_inst", dut.r_inst, 8'h50);
    chk("restart_pc", dut.r_pc, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
